decomp_pipe_ctrl: RTL and testbench

Flow and frame sequencer for the lockstep 256-bit AXI4-stream decompression pipeline.
- Generates the single global stage-advance enable, which all datapath stages use as their ready/enable.
- Tracks per-stage valid, header and last tags, and sequences each frame through header and payload phases.
- Isolates frames: a new frame is not accepted until the previous frame has fully drained.
- Sits between the s2c input port and the datapath stages; the datapath carries data, this block carries control only.

---
 rtl/decomp_pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_decomp_pipe_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decomp_pipe_ctrl.sv
// Control-only flow/frame sequencer for the lockstep decompression pipeline.
// Define DECOMP_PIPE_STATS_EN to add saturating frame/beat/stall counters.
module decomp_pipe_ctrl #(
    parameter int DEPTH     = 5,
    parameter int HDR_BEATS = 1,
    parameter int CNT_W     = 16
) (
    input  logic             axis_aclk,
    input  logic             axis_aresetn,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    input  logic             m_tready,
    output logic             stage_en,
    output logic [DEPTH-1:0] stage_vld,
    output logic [DEPTH-1:0] stage_hdr,
    output logic             out_valid,
    output logic             out_last,
    output logic             out_is_header,
    output logic             busy
`ifdef DECOMP_PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_frames,
    output logic [CNT_W-1:0] stat_beats,
    output logic [CNT_W-1:0] stat_stalls
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_FLUSH} state_t;

    localparam logic [CNT_W-1:0] HDR_BEATS_C = CNT_W'(HDR_BEATS);
    localparam logic             HDR_ONE     = (HDR_BEATS == 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_hdr;
    logic [DEPTH-1:0] r_last;

    logic             w_stage_en;
    logic             w_acc;
    logic             w_hdr_now;
    logic [CNT_W-1:0] w_cnt_next;

    // Bubbles never collapse: the whole pipe advances only when the tail can move.
    assign w_stage_en = !r_vld[DEPTH-1] | m_tready;
    // NOTE: s_tready is gated by reset so upstream never sees a handshake while held in reset.
    assign s_tready   = axis_aresetn & w_stage_en & (r_state != ST_FLUSH);
    assign w_acc      = s_tvalid & s_tready;
    assign w_hdr_now  = (r_state == ST_IDLE) | (r_state == ST_HDR);
    assign w_cnt_next = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + 1'b1;

    assign stage_en      = w_stage_en;
    assign stage_vld     = r_vld;
    assign stage_hdr     = r_hdr;
    assign out_valid     = r_vld[DEPTH-1];
    assign out_last      = r_vld[DEPTH-1] & r_last[DEPTH-1];
    assign out_is_header = r_vld[DEPTH-1] & r_hdr[DEPTH-1];
    assign busy          = (r_state != ST_IDLE) | (|r_vld);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_vld  <= '0;
            r_hdr  <= '0;
            r_last <= '0;
        end else if (w_stage_en) begin
            r_vld  <= {r_vld[DEPTH-2:0],  w_acc};
            r_hdr  <= {r_hdr[DEPTH-2:0],  w_acc & w_hdr_now};
            r_last <= {r_last[DEPTH-2:0], w_acc & s_tlast};
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_beat_cnt <= CNT_W'(1);
                        if (s_tlast)      r_state <= ST_FLUSH;
                        else if (HDR_ONE) r_state <= ST_PAY;
                        else              r_state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_acc) begin
                        r_beat_cnt <= w_cnt_next;
                        if (s_tlast)                        r_state <= ST_FLUSH;
                        else if (w_cnt_next == HDR_BEATS_C) r_state <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (w_acc) begin
                        r_beat_cnt <= w_cnt_next;
                        if (s_tlast) r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Frame isolation: reopen only once the registered pipe is empty.
                    if (r_vld == '0) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DECOMP_PIPE_STATS_EN
    logic w_out_hs;
    assign w_out_hs = r_vld[DEPTH-1] & m_tready;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            stat_frames <= '0;
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (w_out_hs && out_last && stat_frames != '1) stat_frames <= stat_frames + 1'b1;
            if (w_out_hs && stat_beats != '1)              stat_beats  <= stat_beats + 1'b1;
            if (r_vld[DEPTH-1] && !m_tready && stat_stalls != '1)
                stat_stalls <= stat_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decomp_pipe_ctrl.sv
// Directed table-driven bench for decomp_pipe_ctrl; two instances (HDR_BEATS=1 and 2) share stimulus.
module tb_decomp_pipe_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic s_tvalid = 1'b0;
    logic s_tlast = 1'b0;
    logic m_tready = 1'b1;

    logic       a_s_tready, a_stage_en, a_out_valid, a_out_last, a_out_is_header, a_busy;
    logic [4:0] a_stage_vld, a_stage_hdr;
    logic       b_s_tready, b_stage_en, b_out_valid, b_out_last, b_out_is_header, b_busy;
    logic [4:0] b_stage_vld, b_stage_hdr;
`ifdef DECOMP_PIPE_STATS_EN
    logic [15:0] a_stat_frames, a_stat_beats, a_stat_stalls;
    logic [15:0] b_stat_frames, b_stat_beats, b_stat_stalls;
`endif

    always #5 clk = ~clk;

    decomp_pipe_ctrl #(.DEPTH(5), .HDR_BEATS(1), .CNT_W(16)) u_dut_a (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(a_s_tready), .m_tready(m_tready), .stage_en(a_stage_en),
        .stage_vld(a_stage_vld), .stage_hdr(a_stage_hdr), .out_valid(a_out_valid),
        .out_last(a_out_last), .out_is_header(a_out_is_header), .busy(a_busy)
`ifdef DECOMP_PIPE_STATS_EN
        , .stat_frames(a_stat_frames), .stat_beats(a_stat_beats), .stat_stalls(a_stat_stalls)
`endif
    );

    decomp_pipe_ctrl #(.DEPTH(5), .HDR_BEATS(2), .CNT_W(16)) u_dut_b (
        .axis_aclk(clk), .axis_aresetn(rst_n), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(b_s_tready), .m_tready(m_tready), .stage_en(b_stage_en),
        .stage_vld(b_stage_vld), .stage_hdr(b_stage_hdr), .out_valid(b_out_valid),
        .out_last(b_out_last), .out_is_header(b_out_is_header), .busy(b_busy)
`ifdef DECOMP_PIPE_STATS_EN
        , .stat_frames(b_stat_frames), .stat_beats(b_stat_beats), .stat_stalls(b_stat_stalls)
`endif
    );

    // in: {rst_n, s_tvalid, s_tlast, m_tready}
    // exp: {s_tready, stage_en, out_valid, out_last, hdr_a, hdr_b, busy, stage_vld[4:0]}
    typedef struct {
        logic [3:0]  in;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [3:0] in, input logic [11:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send_frame(input int n, input int gap_at);
        logic ok;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                @(negedge clk);
                s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
            end
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                s_tvalid = 1'b1; s_tlast = (i == n - 1); m_tready = 1'b1;
                #1;
                ok = a_s_tready;
            end
            if (!ok) check("send_accept", a_s_tready, 1);
        end
    endtask

    task automatic drain(input int stalls, output int hs, output logic [7:0] ha,
                         output logic [7:0] hb, output logic [7:0] ll, output logic [15:0] ovp);
        int left;
        left = stalls;
        hs = 0; ha = '0; hb = '0; ll = '0; ovp = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
            #1;
            if (!a_busy) break;
            if (a_out_valid && left > 0) begin
                m_tready = 1'b0;
                left--;
                #1;
            end
            ovp = {ovp[14:0], a_out_valid};
            if (a_out_valid && m_tready) begin
                hs++;
                ha = {ha[6:0], a_out_is_header};
                hb = {hb[6:0], b_out_is_header};
                ll = {ll[6:0], a_out_last};
            end
        end
        check("drain_idle", a_busy, 0);
    endtask

    initial begin
        int         hs_total;
        int         hs;
        logic [7:0] ha, hb, ll;
        logic [15:0] ovp;

        // 4-beat frame, clean drain
        tbl.push_back(mk(4'b0001, 12'b0100_00_0_00000));
        tbl.push_back(mk(4'b1101, 12'b1100_00_0_00000));
        tbl.push_back(mk(4'b1101, 12'b1100_00_1_00001));
        tbl.push_back(mk(4'b1101, 12'b1100_00_1_00011));
        tbl.push_back(mk(4'b1111, 12'b1100_00_1_00111));
        tbl.push_back(mk(4'b1101, 12'b0100_00_1_01111));
        tbl.push_back(mk(4'b1101, 12'b0110_11_1_11110));
        tbl.push_back(mk(4'b1001, 12'b0110_01_1_11100));
        tbl.push_back(mk(4'b1001, 12'b0110_00_1_11000));
        tbl.push_back(mk(4'b1001, 12'b0111_00_1_10000));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00000));
        // 4-beat frame with 3 stall cycles at the output
        tbl.push_back(mk(4'b1101, 12'b1100_00_0_00000));
        tbl.push_back(mk(4'b1101, 12'b1100_00_1_00001));
        tbl.push_back(mk(4'b1101, 12'b1100_00_1_00011));
        tbl.push_back(mk(4'b1111, 12'b1100_00_1_00111));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_01111));
        tbl.push_back(mk(4'b1000, 12'b0010_11_1_11110));
        tbl.push_back(mk(4'b1000, 12'b0010_11_1_11110));
        tbl.push_back(mk(4'b1000, 12'b0010_11_1_11110));
        tbl.push_back(mk(4'b1001, 12'b0110_11_1_11110));
        tbl.push_back(mk(4'b1001, 12'b0110_01_1_11100));
        tbl.push_back(mk(4'b1001, 12'b0110_00_1_11000));
        tbl.push_back(mk(4'b1001, 12'b0111_00_1_10000));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00000));
        // two back-to-back 2-beat frames, s_tvalid held high across the gap
        tbl.push_back(mk(4'b1101, 12'b1100_00_0_00000));
        tbl.push_back(mk(4'b1111, 12'b1100_00_1_00001));
        tbl.push_back(mk(4'b1101, 12'b0100_00_1_00011));
        tbl.push_back(mk(4'b1101, 12'b0100_00_1_00110));
        tbl.push_back(mk(4'b1101, 12'b0100_00_1_01100));
        tbl.push_back(mk(4'b1101, 12'b0110_11_1_11000));
        tbl.push_back(mk(4'b1101, 12'b0111_01_1_10000));
        tbl.push_back(mk(4'b1101, 12'b0100_00_1_00000));
        tbl.push_back(mk(4'b1101, 12'b1100_00_0_00000));
        tbl.push_back(mk(4'b1111, 12'b1100_00_1_00001));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00011));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00110));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_01100));
        tbl.push_back(mk(4'b1001, 12'b0110_11_1_11000));
        tbl.push_back(mk(4'b1001, 12'b0111_01_1_10000));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00000));
        // single-beat frame
        tbl.push_back(mk(4'b1111, 12'b1100_00_0_00000));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00001));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00010));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00100));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_01000));
        tbl.push_back(mk(4'b1001, 12'b0111_11_1_10000));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00000));
        // reset with 3 beats in flight, then a 2-beat frame
        tbl.push_back(mk(4'b1101, 12'b1100_00_0_00000));
        tbl.push_back(mk(4'b1101, 12'b1100_00_1_00001));
        tbl.push_back(mk(4'b1101, 12'b1100_00_1_00011));
        tbl.push_back(mk(4'b1001, 12'b1100_00_1_00111));
        tbl.push_back(mk(4'b0001, 12'b0100_00_0_00000));
        tbl.push_back(mk(4'b1101, 12'b1100_00_0_00000));
        tbl.push_back(mk(4'b1111, 12'b1100_00_1_00001));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00011));
        tbl.push_back(mk(4'b1000, 12'b0100_00_1_00110));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_01100));
        tbl.push_back(mk(4'b1001, 12'b0110_11_1_11000));
        tbl.push_back(mk(4'b1001, 12'b0111_01_1_10000));
        tbl.push_back(mk(4'b1001, 12'b0100_00_1_00000));
        tbl.push_back(mk(4'b1001, 12'b1100_00_0_00000));

        #1 rst_n = 1'b0;

        hs_total = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            {rst_n, s_tvalid, s_tlast, m_tready} = tbl[i].in;
            #1;
            check($sformatf("row%0d_a", i),
                  {a_s_tready, a_stage_en, a_out_valid, a_out_last, a_out_is_header,
                   b_out_is_header, a_busy, a_stage_vld}, tbl[i].exp);
            check($sformatf("row%0d_b", i),
                  {b_s_tready, b_stage_en, b_out_valid, b_out_last, a_out_is_header,
                   b_out_is_header, b_busy, b_stage_vld}, tbl[i].exp);
            if (a_out_valid && m_tready) hs_total++;
        end
        check("table_handshakes", hs_total, 15);

        // 3-beat frame with an input bubble after beat 1: bubble must travel intact
        send_frame(3, 1);
        drain(0, hs, ha, hb, ll, ovp);
        check("bubble_beats", hs, 3);
        check("bubble_hdr_a", ha, 8'b100);
        check("bubble_hdr_b", hb, 8'b110);
        check("bubble_last", ll, 8'b001);
        check("bubble_ovalid_pattern", ovp, 16'b010110);

`ifdef DECOMP_PIPE_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("stats_rst_frames", a_stat_frames, 0);
        check("stats_rst_beats", a_stat_beats, 0);
        check("stats_rst_stalls", a_stat_stalls, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send_frame(5, -1);
            drain((f == 0) ? 2 : 0, hs, ha, hb, ll, ovp);
            check($sformatf("stats_frame%0d_beats", f), hs, 5);
        end
        check("stat_frames", a_stat_frames, 3);
        check("stat_beats", a_stat_beats, 15);
        check("stat_stalls", a_stat_stalls, 2);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
